la_capture: RTL
===============

# la_capture

Capture and trigger engine for the 8-channel logic analyser, and the write side of the 1024x8 sample RAM that `la_wave_display` reads. It samples `din` on a sample strobe and keeps a circular pre-trigger history. On a programmable trigger it fills the remaining post-trigger depth. It then reports the trigger sample address to the display and deasserts `trigger_en`, which unblanks the waveform.

## Interface
Parameters:
- none. Depth is fixed at 1024, address width 10, data width 8.

Ports:
- `pclk` in 1: single clock, shared with the display and RAM.
- `rst_n` in 1: reset, synchronous, active-low.
- `din` in 8: channel inputs, already synchronised to `pclk`.
- `sample_en` in 1: sample strobe from the rate divider; one sample per high cycle.
- `arm` in 1: start-capture pulse. Accepted only in IDLE or DONE.
- `abort` in 1: synchronous abort. Return to IDLE with no `done`.
- `trig_mode` in 2: trigger type.
  - 0: level, `(s & trig_mask) == (trig_val & trig_mask)`.
  - 1: rising, `|(trig_mask & s & ~p)`.
  - 2: falling, `|(trig_mask & ~s & p)`.
  - 3: immediate.
- `trig_mask` in 8: channel enable mask for the trigger.
- `trig_val` in 8: level-match pattern, used in mode 0 only.
- `pre_num` in 10: pre-trigger sample count, 0..1023.
- `wr_data` out 8: RAM write data.
- `wr_en` out 1: RAM write enable.
- `wr_addr` out 10: RAM write address.
- `start_addr` out 10: RAM address of the trigger sample.
- `trigger_en` out 1: high from arm until capture completes or aborts. The display blanks waves while it is high.
- `done` out 1: one-cycle pulse when capture completes.

## Operation
Arm and configuration:
- `trig_mode`, `trig_mask`, `trig_val` and `pre_num` are latched on an accepted `arm`. Changes during a capture are ignored.
- Accepting `arm` resets the write pointer `ptr`, clears the prev-valid flag, and sets `trigger_en`.

States:
- IDLE: no writes. Go to PRE on `arm`, or to WAIT when `pre_num`=0.
- PRE: each sample is written; `pre_cnt` increments. When `pre_cnt`+1 == `pre_num`, go to WAIT. Trigger is not evaluated in PRE.
- WAIT: each sample is written, wrapping circularly. Trigger is evaluated on the sample being written.
  - On a hit: `start_addr`<=`ptr` and `post_cnt`<=1. Go to POST, or straight to DONE when `pre_num`=1023.
- POST: each sample is written; `post_cnt` increments. When `post_cnt`+1 == 1024−`pre_num` (11-bit compare), go to DONE.
- DONE: no writes, `trigger_en`=0, contents and `start_addr` held. `arm` re-arms.

Write and trigger rules:
- Sample write: `wr_data`<=`din`, `wr_addr`<=`ptr`, `ptr`<=`ptr`+1 (mod 1024), `wr_en`<=1.
- Every accepted sample, in any capturing state, updates the previous-sample register `p`; `s` is the current `din`.
- Edge modes never hit on the first sample after arm (prev-valid=0).
- Level mode with `trig_mask`=0 hits on the first WAIT sample.

Priority and exceptions:
- Priority order: `rst_n` > `abort` > `arm` > `sample_en`.
- `abort` in any capturing state: go to IDLE, `trigger_en`<=0, `wr_en`<=0, no `done`, RAM contents undefined for display.
- `arm` while in PRE, WAIT or POST is ignored.
- `sample_en` in the same cycle as an accepted `arm` is dropped. The first sample is the next strobe.

Capture content:
- The trigger sample counts as the first post sample.
- Total post samples = 1024−`pre_num`.
- Final buffer: oldest sample at `start_addr`−`pre_num`, last at `start_addr`+1023−`pre_num` (mod 1024).

## Timing
Reset values:
- `wr_en`=0, `wr_data`=0, `wr_addr`=0, `start_addr`=0, `trigger_en`=0, `done`=0, state IDLE.

Latencies:
- `sample_en` at cycle t: write visible (`wr_en`=1, `wr_data`=`din`(t)) during t+1. `wr_en` is high exactly one cycle per accepted sample.
- Trigger decision is combinational on `din`(t) and `p`. The state change, `start_addr` and `post_cnt` update at the same edge.
- Last POST write at t+1: `done`=1 during t+1 and `trigger_en`=0 from t+1 on. `done` is coincident with the final `wr_en`.
- `arm` at cycle a: `trigger_en`=1 from a+1.
- `abort` at cycle a: `trigger_en`=0 and `wr_en`=0 from a+1.
- `rst_n` low at any point: all outputs at reset values on the next edge.
- No throughput limit: `sample_en` may be high every cycle.

## Test plan
- Level trigger, `pre_num`=100, mask=0x01, val=0x01, `sample_en` every cycle, `din`=0x00 for 300 samples then 0x01:
  - `start_addr`=300; total 1224 writes.
  - Last `wr_addr`=199 (wrap); `done` pulses once, `trigger_en` falls the same cycle.
- Rising mode, mask=0x80, `din`=0x80 from the first sample, falls at sample 10 and rises at sample 20 (`pre_num`=0):
  - No hit at sample 0; `start_addr`=20.
- Immediate mode, `pre_num`=0: `start_addr`=0, exactly 1024 writes at addresses 0..1023, then `done`.
- `pre_num`=1023, immediate:
  - 1023 PRE writes, then the trigger write at address 1023 with `start_addr`=1023.
  - `done` on that write; no further writes.
- `abort` in WAIT after 500 writes:
  - `trigger_en`=0 next cycle, no `done`, no more writes.
  - Re-`arm`: first write at address 0.
- `sample_en` one cycle in 4, falling mode: one `wr_en` cycle per strobe, each one cycle after its strobe, with `wr_data` equal to `din` at the strobe. `arm` pulses during capture cause no change.

Source files
------------

// File: rtl/la_capture.sv
// ---------------------------------------------------------------------------
// la_capture
//   Capture and trigger engine for the 8-channel logic analyser. It is also
//   the write side of the 1024x8 sample RAM that la_wave_display reads.
//
//   After an accepted arm, samples of din are written to the RAM on each
//   sample_en strobe. The engine first collects pre_num pre-trigger samples.
//   It then writes circularly while it waits for the trigger, and finally
//   fills the remaining 1024-pre_num post-trigger slots. The trigger sample
//   counts as the first post-trigger sample. At completion the engine pulses
//   done, drops trigger_en (which unblanks the display) and holds start_addr
//   at the RAM address of the trigger sample.
//
// Ports
//   pclk        in   clock shared with display and RAM
//   rst_n       in   synchronous active-low reset
//   din[7:0]    in   channel inputs, already synchronous to pclk
//   sample_en   in   sample strobe, one sample per high cycle
//   arm         in   start-capture pulse, accepted in IDLE or DONE only
//   abort       in   cancel an ongoing capture, no done
//   trig_mode   in   0 level, 1 rising, 2 falling, 3 immediate
//   trig_mask   in   channel enable mask for the trigger
//   trig_val    in   level pattern (mode 0 only)
//   pre_num     in   pre-trigger sample count, 0..1023
//   wr_data     out  RAM write data
//   wr_en       out  RAM write enable
//   wr_addr     out  RAM write address
//   start_addr  out  RAM address of the trigger sample
//   trigger_en  out  high from arm until completion or abort
//   done        out  one-cycle pulse, coincident with the final write
//
// State | meaning
//   ST_IDLE | no capture; waiting for arm
//   ST_PRE  | collecting the pre-trigger history; trigger not evaluated
//   ST_WAIT | circular writes; trigger evaluated on every written sample
//   ST_POST | filling the post-trigger depth after the hit
//   ST_DONE | buffer complete, contents and start_addr held until re-arm
// ---------------------------------------------------------------------------
module la_capture (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       sample_en,
  input  logic       arm,
  input  logic       abort,
  input  logic [1:0] trig_mode,
  input  logic [7:0] trig_mask,
  input  logic [7:0] trig_val,
  input  logic [9:0] pre_num,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic [9:0] start_addr,
  output logic       trigger_en,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // Configuration captured on an accepted arm
  logic [1:0]  mode_q;
  logic [7:0]  mask_q;
  logic [7:0]  val_q;
  logic [9:0]  pre_q;

  // Capture datapath
  logic [9:0]  ptr;
  logic [9:0]  pre_cnt;
  logic [10:0] post_cnt;
  logic [7:0]  prev_smp;
  logic        prev_valid;

  // Decoded control
  logic        capturing;
  logic        abort_now;
  logic        arm_ok;
  logic        smp;
  logic        trig_hit;
  logic        hit_now;
  logic        pre_last;
  logic        post_last;
  logic        fin;

  // -------------------------------------------------------------------------
  // Trigger evaluation on the sample about to be written (s = din, p = last
  // accepted sample). The edge modes need a valid previous sample, so they
  // cannot fire on the first sample after arm.
  // -------------------------------------------------------------------------
  always_comb begin
    trig_hit = 1'b0;
    unique case (mode_q)
      2'd0:    trig_hit = ((din & mask_q) == (val_q & mask_q));
      2'd1:    trig_hit = prev_valid && (|(mask_q & din & ~prev_smp));
      2'd2:    trig_hit = prev_valid && (|(mask_q & ~din & prev_smp));
      default: trig_hit = 1'b1;
    endcase
  end

  // pre_cnt never exceeds 1022 while in PRE, so the 10-bit add cannot wrap.
  assign pre_last  = ((pre_cnt + 10'd1) == pre_q);
  // Post depth is 1024-pre_num, which needs 11 bits when pre_num is 0.
  assign post_last = ((post_cnt + 11'd1) == (11'd1024 - {1'b0, pre_q}));

  // -------------------------------------------------------------------------
  // Next-state and control decode.
  // Priority: abort > arm > sample_en. Arm is only honoured outside a
  // capture. Because of that, a strobe that coincides with an accepted arm
  // is dropped automatically: no sample is ever taken in IDLE or DONE.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    capturing = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST);
    abort_now = abort && capturing;
    arm_ok    = 1'b0;
    smp       = 1'b0;
    hit_now   = 1'b0;
    fin       = 1'b0;

    if (abort) begin
      if (capturing) begin
        state_nxt = ST_IDLE;
      end
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            arm_ok    = 1'b1;
            state_nxt = (pre_num == 10'd0) ? ST_WAIT : ST_PRE;
          end
        end
        ST_PRE: begin
          smp = sample_en;
          if (sample_en && pre_last) begin
            state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          smp = sample_en;
          if (sample_en && trig_hit) begin
            hit_now = 1'b1;
            // With 1023 pre samples the trigger write is the whole post depth.
            if (pre_q == 10'd1023) begin
              state_nxt = ST_DONE;
              fin       = 1'b1;
            end else begin
              state_nxt = ST_POST;
            end
          end
        end
        ST_POST: begin
          smp = sample_en;
          if (sample_en && post_last) begin
            state_nxt = ST_DONE;
            fin       = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      mode_q     <= 2'd0;
      mask_q     <= 8'h00;
      val_q      <= 8'h00;
      pre_q      <= 10'd0;
      ptr        <= 10'd0;
      pre_cnt    <= 10'd0;
      post_cnt   <= 11'd0;
      prev_smp   <= 8'h00;
      prev_valid <= 1'b0;
      wr_data    <= 8'h00;
      wr_en      <= 1'b0;
      wr_addr    <= 10'd0;
      start_addr <= 10'd0;
      trigger_en <= 1'b0;
      done       <= 1'b0;
    end else begin
      wr_en <= smp;
      done  <= fin;

      if (smp) begin
        wr_data    <= din;
        wr_addr    <= ptr;
        ptr        <= ptr + 10'd1;
        prev_smp   <= din;
        prev_valid <= 1'b1;
      end

      if (smp && (state == ST_PRE)) begin
        pre_cnt <= pre_cnt + 10'd1;
      end

      if (smp && (state == ST_POST)) begin
        post_cnt <= post_cnt + 11'd1;
      end

      // The trigger sample is post sample number one.
      if (hit_now) begin
        start_addr <= ptr;
        post_cnt   <= 11'd1;
      end

      if (arm_ok) begin
        mode_q     <= trig_mode;
        mask_q     <= trig_mask;
        val_q      <= trig_val;
        pre_q      <= pre_num;
        ptr        <= 10'd0;
        pre_cnt    <= 10'd0;
        post_cnt   <= 11'd0;
        prev_valid <= 1'b0;
        trigger_en <= 1'b1;
      end

      if (abort_now || fin) begin
        trigger_en <= 1'b0;
      end
    end
  end

endmodule
